// File: rtl/neural_soc_sysid_ext.sv
// System-ID / uptime / scratch slave: read-only ID words, 64-bit uptime counter with a coherent
// high-word shadow, and byte-enabled scratch registers. Reads are returned READ_LATENCY cycles later.
module neural_soc_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          READ_LATENCY = 1,
    parameter int          NUM_SCRATCH  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [7:0] NUM_SCRATCH_B  = 8'(NUM_SCRATCH);
    localparam logic [7:0] READ_LATENCY_B = 8'(READ_LATENCY);
    localparam logic [31:0] CAPS = {16'h0000, NUM_SCRATCH_B, READ_LATENCY_B};

    logic [63:0] counter;
    logic [31:0] shadow;
    logic        en;
    logic [31:0] scratch [8];

    logic        rd_acc;
    logic        ctrl_wr;
    logic        scr_ok;
    logic        scr_wr;
    logic [31:0] rd_val;
    logic [32:0] stage_in;
    logic [READ_LATENCY-1:0][32:0] pipe;

    // A simultaneous write wins; the read is dropped entirely.
    assign rd_acc  = read & ~write;
    assign ctrl_wr = write && (address == 4'd3) && byteenable[0];
    assign scr_ok  = address[3] && ({1'b0, address[2:0]} < 4'(NUM_SCRATCH));
    assign scr_wr  = write && scr_ok;

    always_comb begin
        rd_val = '0;
        case (address)
            4'd0:    rd_val = SYSTEM_ID;
            4'd1:    rd_val = TIMESTAMP;
            4'd2:    rd_val = VERSION;
            4'd3:    rd_val = {31'd0, en};
            4'd4:    rd_val = counter[31:0];
            4'd5:    rd_val = shadow;
            4'd6:    rd_val = CAPS;
            default: if (scr_ok) rd_val = scratch[address[2:0]];
        endcase
    end

    // Counter always takes an assignment so a held value is an explicit +0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
            shadow  <= '0;
            en      <= 1'b1;
        end else begin
            if (ctrl_wr && writedata[1])
                counter <= '0;
            else
                counter <= counter + {63'd0, en};
            if (ctrl_wr)
                en <= writedata[0];
            if (rd_acc && (address == 4'd4))
                shadow <= counter[63:32];
        end
    end

    // Slots at or beyond NUM_SCRATCH are never written and stay at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                scratch[i] <= '0;
        end else if (scr_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) == address[2:0]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b])
                            scratch[i][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign stage_in = {rd_acc, rd_acc ? rd_val : 32'd0};

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    pipe <= '0;
                else
                    pipe <= stage_in;
            end
        end else begin : g_latn
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    pipe <= '0;
                else
                    pipe <= {pipe[READ_LATENCY-2:0], stage_in};
            end
        end
    endgenerate

    assign readdatavalid = pipe[READ_LATENCY-1][32];
    assign readdata      = pipe[READ_LATENCY-1][31:0];

endmodule

// File: tb/tb_neural_soc_sysid_ext.sv
// Scoreboard bench: a register-map model predicts each read; a monitor checks strobe timing and data.
module tb_neural_soc_sysid_ext;

    localparam int          RL  = 2;
    localparam int          NS  = 2;
    localparam logic [31:0] SID = 32'hCAFE_0001;
    localparam logic [31:0] TS  = 32'h5837_2FA9;
    localparam logic [31:0] VER = 32'h0001_0000;
    localparam logic [63:0] FORCE_VAL = 64'h0000_0001_FFFF_FFFE;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    neural_soc_sysid_ext #(
        .SYSTEM_ID(SID), .TIMESTAMP(TS), .VERSION(VER),
        .READ_LATENCY(RL), .NUM_SCRATCH(NS)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] dat;
        int          due;
        int          addr;
    } exp_t;

    exp_t        expq[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic        m_en;
    logic [31:0] m_scr [NS];
    bit          load_pending = 1'b0;

    function automatic logic [31:0] ref_read(input int a);
        if (a == 0) return SID;
        if (a == 1) return TS;
        if (a == 2) return VER;
        if (a == 3) return {31'd0, m_en};
        if (a == 4) return m_cnt[31:0];
        if (a == 5) return m_shadow;
        if (a == 6) return {16'h0000, 8'(NS), 8'(RL)};
        if (a >= 8 && a < 8 + NS) return m_scr[a - 8];
        return 32'd0;
    endfunction

    // Reference model: one step per rising edge, reads see the state before the edge.
    initial begin
        logic [63:0] nxt_cnt;
        logic        nxt_en;
        int          a;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                m_cnt = '0;
                m_shadow = '0;
                m_en = 1'b1;
                for (int i = 0; i < NS; i++) m_scr[i] = '0;
            end else begin
                a = int'(address);
                nxt_cnt = m_en ? m_cnt + 64'd1 : m_cnt;
                nxt_en = m_en;
                if (read && !write) begin
                    expq.push_back('{dat: ref_read(a), due: cyc + RL - 1, addr: a});
                    if (a == 4) m_shadow = m_cnt[63:32];
                end
                if (write) begin
                    if (a == 3 && byteenable[0]) begin
                        nxt_en = writedata[0];
                        if (writedata[1]) nxt_cnt = '0;
                    end
                    if (a >= 8 && a < 8 + NS) begin
                        for (int b = 0; b < 4; b++)
                            if (byteenable[b]) m_scr[a - 8][8*b +: 8] = writedata[8*b +: 8];
                    end
                end
                m_cnt = nxt_cnt;
                m_en = nxt_en;
                if (load_pending) begin
                    m_cnt = FORCE_VAL;
                    load_pending = 1'b0;
                end
            end
        end
    end

    // Monitor: samples mid-cycle, pops one expectation per strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            vectors++;
            if (readdatavalid) begin
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_strobe cyc=%0d data=%h, required no strobe", cyc, readdata);
                end else begin
                    e = expq.pop_front();
                    if (e.due != cyc || readdata !== e.dat) begin
                        miscompares++;
                        $display("FAIL read_a%0d got %h at cyc %0d, required %h at cyc %0d",
                                 e.addr, readdata, cyc, e.dat, e.due);
                    end
                end
            end else begin
                if (readdata !== 32'd0) begin
                    miscompares++;
                    $display("FAIL idle_data cyc=%0d got %h, required 0", cyc, readdata);
                end
                if (expq.size() > 0 && expq[0].due < cyc) begin
                    e = expq.pop_front();
                    miscompares++;
                    $display("FAIL missing_strobe read_a%0d got none, required %h at cyc %0d",
                             e.addr, e.dat, e.due);
                end
            end
        end
    end

    task automatic op(input bit r, input bit w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        read = r;
        write = w;
        address = a;
        writedata = d;
        byteenable = be;
        @(posedge clock);
        #2;
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        op(1'b1, 1'b0, a, 32'd0, 4'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        op(1'b0, 1'b1, a, d, be);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;

        // ID block back-to-back, then reset values of the writable state
        rd(4'd0); rd(4'd1); rd(4'd2); rd(4'd6); rd(4'd7);
        rd(4'd3); rd(4'd5); rd(4'd8); rd(4'd9); rd(4'd4);
        idle(4);

        // scratch byte lanes and out-of-range slot
        wr(4'd8, 32'h1234_5678, 4'b1111);
        wr(4'd8, 32'hAABB_CCDD, 4'b0101);
        rd(4'd8);
        wr(4'(8 + NS), 32'hDEAD_BEEF, 4'b1111);
        rd(4'(8 + NS));
        wr(4'd15, 32'h0BAD_F00D, 4'b1111);
        rd(4'd15);
        idle(4);

        // coherence across a low-word carry: hold the counter while it is loaded
        wr(4'd3, 32'd0, 4'b0001);
        force dut.counter = FORCE_VAL;
        load_pending = 1'b1;
        idle(1);
        release dut.counter;
        wr(4'd3, 32'd1, 4'b0001);
        rd(4'd4);
        idle(4);
        rd(4'd5);
        idle(4);

        // enable/clear control
        wr(4'd3, 32'd0, 4'b1111);
        rd(4'd4);
        idle(8);
        rd(4'd4);
        wr(4'd3, 32'd3, 4'b1111);
        rd(4'd4);
        rd(4'd3);
        idle(3);
        rd(4'd4);
        wr(4'd3, 32'd2, 4'b1110);
        rd(4'd3);
        idle(4);

        // read/write collision on scratch 1
        op(1'b1, 1'b1, 4'd9, 32'h5A5A_A5A5, 4'b1111);
        rd(4'd9);
        idle(4);

        // reset with two reads in flight
        rd(4'd8);
        rd(4'd9);
        reset = 1'b1;
        expq.delete();
        idle(2);
        reset = 1'b0;
        idle(4);
        rd(4'd8); rd(4'd9); rd(4'd3); rd(4'd5);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        for (int i = 0; i < 20 && expq.size() > 0; i++) idle(1);
        if (expq.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d, required 0", expq.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neural_soc_sysid_ext.md
# neural_soc_sysid_ext

Parametrised system-identification and uptime slave for the neural SoC Qsys fabric. It exposes a read-only ID block (system ID, build timestamp, version, capability word), a free-running 64-bit uptime counter with a coherent high-word snapshot, and a bank of read/write scratch registers. Reads return through a configurable-latency pipeline. Software uses it to confirm the loaded bitstream, time inference runs, and check bus integrity.

## Interface
Parameters:
- SYSTEM_ID, 32'h0000_0000: value returned at word 0.
- TIMESTAMP, 32'h0000_0000: build timestamp returned at word 1.
- VERSION, 32'h0001_0000: block/firmware version returned at word 2.
- READ_LATENCY, 1: cycles from read acceptance to readdatavalid. Legal range 1..4.
- NUM_SCRATCH, 2: number of scratch registers. Legal range 1..8.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  4  word address.
- read  in  1  read request; accepted every cycle it is high.
- write  in  1  write request; accepted every cycle it is high.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  read data; valid only while readdatavalid=1, 0 otherwise.
- readdatavalid  out  1  one-cycle strobe per accepted read.

## Operation
- No waitrequest. Every request is accepted in the cycle it is presented.
- Register map (word address):
  - 0: SYSTEM_ID, RO.
  - 1: TIMESTAMP, RO.
  - 2: VERSION, RO.
  - 3: CTRL.
    - bit0 EN: RW, reset 1.
    - bit1 CLR: write-1 pulse, reads 0.
    - bits 31:2: read 0.
  - 4: UPTIME_LO, RO. Returns counter[31:0]. The same read loads shadow ← counter[63:32].
  - 5: UPTIME_HI, RO. Returns the shadow, reset 0.
  - 6: CAPS, RO: {16'h0, NUM_SCRATCH[7:0], READ_LATENCY[7:0]}.
  - 8..8+NUM_SCRATCH-1: SCRATCHn, RW, reset 0. Byteenable applies per lane.
  - All other addresses read 0, and writes to them are ignored. This includes scratch slots at or beyond NUM_SCRATCH.
- CTRL writes honour byteenable[0] only.
- Uptime counter:
  - 64 bits; increments by 1 every cycle while EN=1.
  - Wraps from 2^64-1 to 0.
  - A CLR write sets the counter to 0 on the next edge. Counting resumes the following cycle if EN=1.
- CTRL write with both EN and CLR fields: clear is applied, and EN takes the written value in the same edge.
- read and write both high in one cycle: the write is performed, the read is dropped, and no readdatavalid is produced.
- Read sampling:
  - Register value is sampled at the acceptance edge (pre-write state of that edge).
  - The sample is pushed into a READ_LATENCY-deep shift pipeline of {valid, data}.
  - Back-to-back reads are fully pipelined: N consecutive reads give N consecutive readdatavalid strobes, in order.
- Reading UPTIME_LO then UPTIME_HI yields a coherent 64-bit value, regardless of intervening cycles or carries.

## Timing
- Reset (asynchronous assert, release synchronous to clock):
  - counter = 0, shadow = 0, EN = 1, scratches = 0.
  - Pipeline cleared: readdatavalid = 0, readdata = 0.
- Reset mid-operation: all reads in flight are discarded, and no strobe emerges after reset deassertion.
- Read latency:
  - read at edge t gives readdatavalid=1 during cycle t+READ_LATENCY, for exactly one cycle.
  - With READ_LATENCY=1, data is registered once.
- Write effect: visible to a read accepted at the next edge or later.
- Counter at a sample edge: counter value before that edge's increment. Two UPTIME_LO reads k cycles apart (EN=1, no clear) differ by exactly k.

## Test plan
- Reset/ID readout:
  - Stimulus: release reset, SYSTEM_ID=32'hCAFE_0001, TIMESTAMP=32'h5837_2FA9; read words 0, 1, 2, 6, 7 back-to-back (READ_LATENCY=2).
  - Required response: five consecutive strobes 2 cycles after each read, with data CAFE_0001, 5837_2FA9, 0001_0000, 0000_0202, 0.
- Scratch with byteenable:
  - Stimulus: write 32'h1234_5678 to word 8 with be=4'b1111, then 32'hAABB_CCDD with be=4'b0101; read word 8.
  - Required response: 32'h12BB_56DD.
- Out-of-range scratch:
  - Stimulus: write word 8+NUM_SCRATCH, then read it.
  - Required response: 0.
- Uptime coherence:
  - Stimulus: force counter to 64'h0000_0001_FFFF_FFFE; read LO at t, HI at t+5.
  - Required response: FFFF_FFFE and 0000_0001, even though the carry occurs between the reads.
- Counter control:
  - Stimulus: write CTRL=0 (disable) and wait 10 cycles with two LO reads.
  - Required response: equal LO values.
  - Stimulus: write CTRL=3.
  - Required response: next LO read within 3 cycles is ≤ 2, and CTRL reads back 1.
- Collision and reset:
  - Stimulus: read and write both high on word 9.
  - Required response: write lands, no readdatavalid.
  - Stimulus: assert reset while 2 reads are in flight.
  - Required response: readdatavalid stays 0 and scratches read 0 afterwards.
